// File: rtl/enc_pkg.sv
// Shared constants, the search result payload and the helper functions used by
// the round-robin priority encoder.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest request vector the helpers accept; callers zero-extend into it.
    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_W = 6;

    typedef struct packed {
        logic             found;
        logic [MAX_W-1:0] idx;
    } pick_t;

    // Lowest set bit of vec, with a flag saying whether any bit was set.
    function automatic pick_t lowest_set(input logic [MAX_N-1:0] vec);
        pick_t r;
        r = '0;
        for (int i = int'(MAX_N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = MAX_W'(i);
            end
        end
        return r;
    endfunction

    // True when two or more bits of vec are set.
    function automatic logic popcnt_gt1(input logic [MAX_N-1:0] vec);
        return (vec & (vec - MAX_N'(1))) != '0;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection.
// Ports: req_i     request vector
//        ptr_i     round-robin start index
//        rr_mode_i 0 = lowest index wins, 1 = lowest index >= ptr_i, wrapping
//        idx_o     winning index (0 when nothing is requested)
//        found_o   at least one request was set
module prio_pick
    import enc_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic         rr_mode_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [N-1:0] mask;
    pick_t        pick_masked;
    pick_t        pick_all;
    logic         unused_bits;

    // Masked search from the pointer upward; unmasked search covers the wrap.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (rr_mode_i != MODE_RR) || (i >= int'(ptr_i));
        end
        pick_masked = lowest_set(MAX_N'(req_i & mask));
        pick_all    = lowest_set(MAX_N'(req_i));
        idx_o       = pick_masked.found ? W'(pick_masked.idx) : W'(pick_all.idx);
        found_o     = pick_all.found;
    end

    // Upper index bits beyond W are always zero for valid N.
    assign unused_bits = ^{pick_masked, pick_all};

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin priority
// and a valid/ready output that holds under backpressure.
// Ports: clk, rst (sync, active high)
//        req        level requests, bit i from source i
//        rr_mode    0 = fixed (lowest index), 1 = round-robin
//        out_ready  consumer accepts current result
//        out_valid  result valid
//        out_idx    winning index
//        out_onehot one-hot of winner, 0 when not valid
//        out_multi  more than one request set when the result was captured
module rr_priority_encoder
    import enc_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         rr_mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [N-1:0] out_onehot_q, out_onehot_d;
    logic         out_multi_q, out_multi_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         hs;
    logic         load;
    logic [W-1:0] ptr_nxt;
    logic [W-1:0] pick_idx;
    logic         pick_found;

    // Pointer advances past the winner on every accepted result.
    always_comb begin
        hs      = out_valid_q && out_ready;
        load    = !out_valid_q || out_ready;
        ptr_nxt = ptr_q;
        if (hs) begin
            ptr_nxt = (out_idx_q == W'(N - 1)) ? '0 : out_idx_q + W'(1);
        end
    end

    // Selection uses the already-advanced pointer so held requests rotate without a bubble.
    prio_pick #(.N(N)) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_nxt),
        .rr_mode_i (rr_mode),
        .idx_o     (pick_idx),
        .found_o   (pick_found)
    );

    // Next-state: capture only on load, otherwise hold everything.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        out_multi_d  = out_multi_q;
        ptr_d        = ptr_nxt;
        if (load) begin
            out_valid_d = pick_found;
            out_idx_d   = pick_found ? pick_idx : '0;
            out_multi_d = popcnt_gt1(MAX_N'(req));
            for (int i = 0; i < int'(N); i++) begin
                out_onehot_d[i] = pick_found && (pick_idx == W'(i));
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            out_multi_q  <= 1'b0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            out_multi_q  <= out_multi_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign out_multi  = out_multi_q;

endmodule
